// File: rtl/gcd_engine.sv
// Subtractive-Euclid GCD engine with go/busy/done handshake, abort, zero-operand
// handling and an iteration counter; datapath and control share one clocked block.
module gcd_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             abort,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic [WIDTH-1:0] iters,
    output logic             zero_op
);

    // Handshake: go is accepted on a rising edge while idle or in the done cycle;
    // busy is high for every CMP cycle, done is a single-cycle strobe and the
    // result outputs hold until the next completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH-1:0] cnt;
    logic             zflag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            x_r     <= '0;
            y_r     <= '0;
            cnt     <= '0;
            zflag   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            gcd_out <= '0;
            iters   <= '0;
            zero_op <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (go) begin
                        x_r   <= x_in;
                        y_r   <= y_in;
                        cnt   <= '0;
                        zflag <= (x_in == '0) || (y_in == '0);
                        state <= CMP;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                CMP: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (x_r == '0) begin
                        gcd_out <= y_r;
                        iters   <= cnt;
                        zero_op <= zflag;
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if ((y_r == '0) || (x_r == y_r)) begin
                        gcd_out <= x_r;
                        iters   <= cnt;
                        zero_op <= zflag;
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (x_r > y_r) begin
                        // Larger operand is always the minuend, so no underflow.
                        x_r <= x_r - y_r;
                        cnt <= cnt + 1'b1;
                    end else begin
                        y_r <= y_r - x_r;
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine (WIDTH=8): directed cases plus randomized operands checked
// against a division-based Euclid reference model.
module tb_gcd_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] x_in = '0;
    logic [7:0] y_in = '0;
    logic       busy;
    logic       done;
    logic [7:0] gcd_out;
    logic [7:0] iters;
    logic       zero_op;

    int n_cmp = 0;
    int n_err = 0;
    int last_gcd = 0;
    int last_iters = 0;
    int last_zero = 0;

    gcd_engine #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (go),
        .abort   (abort),
        .x_in    (x_in),
        .y_in    (y_in),
        .busy    (busy),
        .done    (done),
        .gcd_out (gcd_out),
        .iters   (iters),
        .zero_op (zero_op)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: gcd by remainders; subtraction count is the sum of Euclid
    // quotients minus one (the engine stops when the operands meet, not at zero).
    function automatic void ref_gcd(input int a_in, input int b_in, output int g, output int k);
        int a, b, t;
        a = a_in;
        b = b_in;
        k = 0;
        if (a == 0 || b == 0) begin
            g = (a == 0) ? b : a;
        end else begin
            while (b != 0) begin
                k += a / b;
                t = a % b;
                a = b;
                b = t;
            end
            g = a;
            k -= 1;
        end
    endfunction

    task automatic do_op(input int x, input int y, input bit pulse);
        int eg, ek, cyc, bcnt;
        bit got;
        ref_gcd(x, y, eg, ek);
        @(negedge clk);
        go = 1'b1;
        x_in = 8'(x);
        y_in = 8'(y);
        @(posedge clk);
        #1;
        go = 1'b0;
        x_in = 8'($urandom_range(0, 255));
        y_in = 8'($urandom_range(0, 255));
        cyc = 0;
        bcnt = 0;
        got = 1'b0;
        while (cyc < 300 && !got) begin
            @(negedge clk);
            cyc++;
            if (busy) bcnt++;
            if (done) begin
                got = 1'b1;
                go = 1'b0;
            end else if (pulse) begin
                go = 1'($urandom_range(0, 1));
                x_in = 8'($urandom_range(0, 255));
                y_in = 8'($urandom_range(0, 255));
            end
        end
        check_val("done_seen", 32'(got), 32'd1);
        check_val("done_latency", 32'(cyc), 32'(ek + 2));
        check_val("busy_cycles", 32'(bcnt), 32'(ek + 1));
        check_val("gcd_out", 32'(gcd_out), 32'(eg));
        check_val("iters", 32'(iters), 32'(ek));
        check_val("zero_op", 32'(zero_op), 32'((x == 0 || y == 0) ? 1 : 0));
        @(negedge clk);
        check_val("done_one_cycle", 32'(done), 32'd0);
        check_val("idle_after", 32'(busy), 32'd0);
        last_gcd = eg;
        last_iters = ek;
        last_zero = (x == 0 || y == 0) ? 1 : 0;
    endtask

    initial begin
        int cyc, bcnt;
        bit got, seen;

        // Reset values
        #12;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_gcd", 32'(gcd_out), 32'd0);
        check_val("rst_iters", 32'(iters), 32'd0);
        check_val("rst_zero", 32'(zero_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed operations, zero operands and the 8-bit worst case
        do_op(48, 18, 1'b0);
        do_op(0, 35, 1'b0);
        do_op(35, 0, 1'b0);
        do_op(0, 0, 1'b0);
        do_op(255, 1, 1'b0);
        do_op(18, 48, 1'b0);

        // Back-to-back with go held high: second op accepted in the done cycle
        @(negedge clk);
        go = 1'b1;
        x_in = 8'd12;
        y_in = 8'd8;
        @(posedge clk);
        #1;
        x_in = 8'd7;
        y_in = 8'd7;
        cyc = 0;
        got = 1'b0;
        while (cyc < 20 && !got) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
        end
        check_val("b2b1_latency", 32'(cyc), 32'd4);
        check_val("b2b1_gcd", 32'(gcd_out), 32'd4);
        check_val("b2b1_iters", 32'(iters), 32'd2);
        @(posedge clk);
        #1;
        go = 1'b0;
        @(negedge clk);
        check_val("b2b2_busy", 32'(busy), 32'd1);
        check_val("b2b2_nodone", 32'(done), 32'd0);
        @(negedge clk);
        check_val("b2b2_done", 32'(done), 32'd1);
        check_val("b2b2_gcd", 32'(gcd_out), 32'd7);
        check_val("b2b2_iters", 32'(iters), 32'd0);
        last_gcd = 7;
        last_iters = 0;
        last_zero = 0;
        @(negedge clk);

        // go pulses during busy are ignored
        do_op(100, 3, 1'b1);

        // Abort on the third busy cycle
        @(negedge clk);
        go = 1'b1;
        x_in = 8'd100;
        y_in = 8'd3;
        @(posedge clk);
        #1;
        go = 1'b0;
        cyc = 0;
        bcnt = 0;
        while (bcnt < 3 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (busy) bcnt++;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_gcd", 32'(gcd_out), 32'(last_gcd));
        check_val("abort_iters", 32'(iters), 32'(last_iters));
        check_val("abort_zero", 32'(zero_op), 32'(last_zero));
        seen = done;
        repeat (6) begin
            @(negedge clk);
            seen = seen | done;
        end
        check_val("abort_no_done", 32'(seen), 32'd0);

        // Asynchronous reset in the middle of an op
        @(negedge clk);
        go = 1'b1;
        x_in = 8'd200;
        y_in = 8'd7;
        @(posedge clk);
        #1;
        go = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_done", 32'(done), 32'd0);
        check_val("arst_gcd", 32'(gcd_out), 32'd0);
        check_val("arst_iters", 32'(iters), 32'd0);
        check_val("arst_zero", 32'(zero_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(9, 6, 1'b0);

        // Randomized operand pairs
        for (int i = 0; i < 1000; i++) begin
            do_op($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gcd_engine.md
# gcd_engine

Parametrised subtractive-Euclid GCD engine: next generation of the GCD control unit, with datapath and FSM merged into one block. Computes gcd(x_in, y_in) for WIDTH-bit unsigned operands. Uses a go/busy/done handshake, handles zero operands explicitly, supports abort and reports the iteration count. Sits between the operand source and the result consumer.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset
- One clock; reset is asynchronous and active-low.
- go  in  1  start request, sampled on rising edge
- abort  in  1  cancels the operation in progress; synchronous
- x_in  in  WIDTH  operand X, captured when go is accepted
- y_in  in  WIDTH  operand Y, captured when go is accepted
- busy  out  1  high while in CMP
- done  out  1  one-cycle completion strobe
- gcd_out  out  WIDTH  result, held until the next completion
- iters  out  WIDTH  number of subtractions in the last completed op
- zero_op  out  1  last completed op had x_in==0 or y_in==0

## Operation
- Internal registers: X, Y (WIDTH), cnt (WIDTH), state ∈ {IDLE, CMP, DONE}.
- IDLE:
  - go=1 → X←x_in, Y←y_in, cnt←0, zflag←(x_in==0 | y_in==0), state←CMP.
  - Otherwise hold.
- CMP, evaluated in priority order:
  - abort=1 → state←IDLE. gcd_out, iters and zero_op are unchanged. No done.
  - X==0 → gcd_out←Y, iters←cnt, zero_op←zflag, state←DONE.
  - Y==0 or X==Y → gcd_out←X, iters←cnt, zero_op←zflag, state←DONE.
  - X>Y → X←X−Y, cnt←cnt+1, stay in CMP.
  - X<Y → Y←Y−X, cnt←cnt+1, stay in CMP.
- DONE:
  - done=1 for this single cycle.
  - go=1 is accepted exactly as in IDLE (back-to-back ops) → CMP. Otherwise → IDLE.
- Arithmetic rules:
  - All unsigned, WIDTH bits.
  - Subtraction never underflows: the larger operand is always the minuend.
- Bound: at most 2^WIDTH−2 subtractions, at (1, 2^WIDTH−1). cnt therefore never wraps and needs no saturation.
- Zero cases:
  - gcd(0,b)=b, gcd(a,0)=a, gcd(0,0)=0.
  - Each completes with iters=0 and zero_op=1.
  - The predecessor's non-termination on zero operands is removed.
- go while in CMP is ignored; operands are not re-sampled.
- abort outside CMP has no effect. abort and go in the same IDLE/DONE cycle → go wins.
- x_in/y_in may change freely after the accepting edge.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, X=Y=cnt=0.
  - busy=0, done=0, gcd_out=0, iters=0, zero_op=0.
  - Asserted mid-operation, the op is discarded and no done is produced.
- Outputs are decoded from registered state/registers (no combinational path from inputs):
  - busy = (state==CMP).
  - done = (state==DONE).
- Latency, with the go-accepting edge as E0 and k subtractions:
  - Edges E1..Ek perform the subtractions.
  - Edge E(k+1) registers gcd_out/iters/zero_op and enters DONE.
  - done is high between E(k+1) and E(k+2).
  - Total: k+2 cycles from go to the end of the done pulse.
- Throughput: a new go may be accepted at E(k+2), during DONE. busy then stays low for exactly one cycle, the DONE cycle.
- gcd_out/iters/zero_op change only at a completing edge or at reset.

## Test plan
- Reset values, then one op:
  - Check all outputs are 0 after reset.
  - go with x=48, y=18 → busy for 5 cycles, done one cycle later, gcd_out=6, iters=4, zero_op=0.
- Zero operands:
  - (0,35) → gcd_out=35.
  - (35,0) → gcd_out=35.
  - (0,0) → gcd_out=0.
  - Each completes with iters=0, zero_op=1, done 2 cycles after go.
- Worst case, WIDTH=8: (255,1) → gcd_out=1, iters=254, done 256 cycles after go. Repeat with WIDTH=16 on (65535,1) → iters=65534.
- Back-to-back and ignored go:
  - go held high continuously with (12,8) then (7,7) → second op accepted in the DONE cycle.
  - Results are 4 (iters 2) then 7 (iters 0).
  - go pulses during busy are ignored.
- Abort: start (100,3), assert abort on the 3rd busy cycle → back to IDLE next edge, no done, gcd_out/iters retain the previous op's values.
- Async reset mid-op: drop rst_n between clock edges during (200,7) → outputs 0 immediately. After release, a new op (9,6) returns 3, iters=2.
- Random: 1000 random operand pairs at WIDTH=8 compared against a reference model for gcd_out, iters and done timing.
